// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-destination select codes and stage entry type
package cpu_pkg;

   // Decode-stage destination select encodings
   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RA = 2'd1;
   localparam logic [1:0] REGDST_SP = 2'd2;
   localparam logic [1:0] REGDST_RD = 2'd3;

   // Architectural register indices for link register and stack pointer
   localparam int RA_REG_IDX = 31;
   localparam int SP_REG_IDX = 29;

   // Default register address width of the register bank
   localparam int REG_ADDR_W = 5;

   // Tracking-pipeline entry at the default address width
   typedef struct packed {
      logic                  v;
      logic [REG_ADDR_W-1:0] addr;
   } stage_entry_t;

endpackage

// File: rtl/reg_dest_sel.sv
// rtl/reg_dest_sel.sv - combinational write-destination register select
module reg_dest_sel
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int RA_REG = RA_REG_IDX,
   parameter int SP_REG = SP_REG_IDX
) (
   input  logic [1:0]        sel,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   output logic [ADDR_W-1:0] dest
);

   localparam logic [ADDR_W-1:0] RA_ADDR = ADDR_W'(RA_REG);
   localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_REG);

   // Every 2-bit select code maps to a destination, so the mux is total
   always_comb begin
      dest = rt;
      case (sel)
         REGDST_RT: dest = rt;
         REGDST_RA: dest = RA_ADDR;
         REGDST_SP: dest = SP_ADDR;
         REGDST_RD: dest = rd;
      endcase
   end

endmodule

// File: rtl/reg_dest_pipe.sv
// rtl/reg_dest_pipe.sv - destination tracking pipeline with pending-write scoreboard
module reg_dest_pipe
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int DEPTH    = 3,
   parameter int RA_REG   = RA_REG_IDX,
   parameter int SP_REG   = SP_REG_IDX
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 sel,
   input  logic [ADDR_W-1:0]          rt,
   input  logic [ADDR_W-1:0]          rd,
   input  logic                       issue,
   input  logic                       reg_write,
   input  logic                       advance,
   input  logic                       flush,
   input  logic [ADDR_W-1:0]          rs_q,
   input  logic [ADDR_W-1:0]          rt_q,
   output logic [ADDR_W-1:0]          dest_now,
   output logic [ADDR_W-1:0]          dest_out,
   output logic                       wb_valid,
   output logic                       wb_fire,
   output logic                       hazard_rs,
   output logic                       hazard_rt,
   output logic [NUM_REGS-1:0]        pending_mask,
   output logic [$clog2(DEPTH+1)-1:0] in_flight
);

   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] addr;
   } stage_t;

   stage_t              stg      [DEPTH];
   logic [NUM_REGS-1:0] mask_acc [DEPTH+1];
   logic [CNT_W-1:0]    cnt_acc  [DEPTH+1];
   logic                head_live;

   reg_dest_sel #(
      .ADDR_W (ADDR_W),
      .RA_REG (RA_REG),
      .SP_REG (SP_REG)
   ) u_sel (
      .sel  (sel),
      .rt   (rt),
      .rd   (rd),
      .dest (dest_now)
   );

   // Writes to $0 are discarded at entry so they never count as pending
   assign head_live = issue & reg_write & (dest_now != '0);

   assign mask_acc[0] = '0;
   assign cnt_acc[0]  = '0;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      stage_t ent;

      if (i == 0) begin : g_head
         // Entry stage: captures the decoded destination when the pipe advances
         always_ff @(posedge clk) begin
            if (reset) begin
               ent.v    <= 1'b0;
               ent.addr <= '0;
            end else if (flush) begin
               ent.v    <= 1'b0;
            end else if (advance) begin
               ent.v    <= head_live;
               ent.addr <= dest_now;
            end
         end
      end else begin : g_tail
         // Later stages: shift the previous stage forward when the pipe advances
         always_ff @(posedge clk) begin
            if (reset) begin
               ent.v    <= 1'b0;
               ent.addr <= '0;
            end else if (flush) begin
               ent.v    <= 1'b0;
            end else if (advance) begin
               ent <= stg[i-1];
            end
         end
      end

      assign stg[i]        = ent;
      assign mask_acc[i+1] = mask_acc[i] | (ent.v ? (NUM_REGS'(1) << ent.addr) : '0);
      assign cnt_acc[i+1]  = cnt_acc[i] + CNT_W'(ent.v);
   end

   assign dest_out     = stg[DEPTH-1].addr;
   assign wb_valid     = stg[DEPTH-1].v;
   assign wb_fire      = wb_valid & advance;
   assign pending_mask = mask_acc[DEPTH];
   assign in_flight    = cnt_acc[DEPTH];
   assign hazard_rs    = (rs_q != '0) & pending_mask[rs_q];
   assign hazard_rt    = (rt_q != '0) & pending_mask[rt_q];

endmodule

// File: tb/tb_reg_dest_pipe.sv
// tb/tb_reg_dest_pipe.sv - self-checking bench for reg_dest_pipe
module tb_reg_dest_pipe;

   localparam int DEPTH = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  sel;
   logic [4:0]  rt, rd, rs_q, rt_q;
   logic        issue, reg_write, advance, flush;
   logic [4:0]  dest_now, dest_out;
   logic        wb_valid, wb_fire, hazard_rs, hazard_rt;
   logic [31:0] pending_mask;
   logic [1:0]  in_flight;

   int n_cmp = 0;
   int n_bad = 0;

   // reference pipeline: element 0 is the youngest slot, last is writeback
   bit mv[$];
   int ma[$];

   reg_dest_pipe #(.ADDR_W(5), .NUM_REGS(32), .DEPTH(DEPTH), .RA_REG(31), .SP_REG(29)) dut (
      .clk(clk), .reset(reset), .sel(sel), .rt(rt), .rd(rd), .issue(issue),
      .reg_write(reg_write), .advance(advance), .flush(flush), .rs_q(rs_q), .rt_q(rt_q),
      .dest_now(dest_now), .dest_out(dest_out), .wb_valid(wb_valid), .wb_fire(wb_fire),
      .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .pending_mask(pending_mask),
      .in_flight(in_flight)
   );

   always #5 clk = ~clk;

   function automatic int m_dest(input logic [1:0] s, input logic [4:0] t, input logic [4:0] d);
      case (s)
         2'd0: return int'(t);
         2'd1: return 31;
         2'd2: return 29;
         default: return int'(d);
      endcase
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] m = '0;
      for (int i = 0; i < DEPTH; i++) if (mv[i]) m[ma[i]] = 1'b1;
      return m;
   endfunction

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) if (mv[i]) c++;
      return c;
   endfunction

   // one rising edge: update the reference with the inputs seen at that edge
   task automatic tick();
      int d;
      @(posedge clk);
      d = m_dest(sel, rt, rd);
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin mv[i] = 0; ma[i] = 0; end
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) mv[i] = 0;
      end else if (advance) begin
         mv.push_front(issue && reg_write && d != 0);
         ma.push_front(d);
         void'(mv.pop_back());
         void'(ma.pop_back());
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1; flush = 0; advance = 1; issue = 0; reg_write = 1;
      sel = 2'd0; rt = 5'd0; rd = 5'd0; rs_q = 5'd8; rt_q = 5'd31;
      tick(); tick();
      reset = 0;
      for (int k = 0; k < 5; k++) begin
         #2;
         n_cmp++;
         if ({dest_now, dest_out, wb_valid, wb_fire, hazard_rs, hazard_rt, pending_mask, in_flight} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle cyc %0d: got dest_out=%0d wbv=%b fire=%b hz=%b%b mask=%h inf=%0d, want all 0",
                     k, dest_out, wb_valid, wb_fire, hazard_rs, hazard_rt, pending_mask, in_flight);
         end
         tick();
      end
   endtask

   task automatic test_single();
      sel = 2'd3; rd = 5'd8; rt = 5'd0; issue = 1; reg_write = 1; advance = 1; rs_q = 5'd8; rt_q = 5'd0;
      #2;
      n_cmp++;
      if (dest_now !== 5'd8 || hazard_rs !== 1'b0) begin
         n_bad++; $display("FAIL single_pre: got dest_now=%0d hz_rs=%b want 8/0", dest_now, hazard_rs);
      end
      tick();
      issue = 0;
      for (int k = 0; k < 4; k++) begin
         #2;
         n_cmp++;
         if (wb_valid !== (k == 2) || wb_fire !== (k == 2)) begin
            n_bad++; $display("FAIL single_wb k=%0d: got wbv=%b fire=%b want %b", k, wb_valid, wb_fire, k == 2);
         end
         n_cmp++;
         if (pending_mask[8] !== (k <= 2) || hazard_rs !== (k <= 2) || hazard_rt !== 1'b0) begin
            n_bad++; $display("FAIL single_hz k=%0d: got mask8=%b hz_rs=%b hz_rt=%b want %b", k, pending_mask[8], hazard_rs, hazard_rt, k <= 2);
         end
         if (k == 2) begin
            n_cmp++;
            if (dest_out !== 5'd8) begin
               n_bad++; $display("FAIL single_dest: got %0d want 8", dest_out);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int seq[$];
      int peak = 0;
      bit bit0 = 0;
      reg_write = 1; advance = 1; rd = 5'd0;
      for (int i = 0; i < 7; i++) begin
         issue = (i < 3);
         sel = (i == 0) ? 2'd1 : (i == 1) ? 2'd2 : 2'd0;
         rt = 5'd0;
         #2;
         if (wb_valid) seq.push_back(int'(dest_out));
         if (int'(in_flight) > peak) peak = int'(in_flight);
         if (pending_mask[0]) bit0 = 1;
         n_cmp++;
         if (int'(in_flight) !== m_cnt()) begin
            n_bad++; $display("FAIL b2b_inflight i=%0d: got %0d want %0d", i, in_flight, m_cnt());
         end
         tick();
      end
      n_cmp++;
      if (seq.size() != 2 || seq[0] != 31 || seq[1] != 29) begin
         n_bad++; $display("FAIL b2b_seq: got %p want '{31,29}", seq);
      end
      n_cmp++;
      if (peak != 2 || bit0) begin
         n_bad++; $display("FAIL b2b_peak: got peak=%0d bit0=%b want 2/0", peak, bit0);
      end
   endtask

   task automatic test_stall();
      sel = 2'd3; rd = 5'd5; issue = 1; reg_write = 1; advance = 1; rs_q = 5'd5; rt_q = 5'd5;
      tick();
      issue = 0;
      tick();
      advance = 0; issue = 1; rd = 5'd17;
      for (int k = 0; k < 4; k++) begin
         #2;
         n_cmp++;
         if (in_flight !== 2'd1 || wb_fire !== 1'b0 || wb_valid !== 1'b0 || pending_mask !== 32'h20 || hazard_rt !== 1'b1) begin
            n_bad++; $display("FAIL stall_hold k=%0d: got inf=%0d fire=%b wbv=%b mask=%h hz_rt=%b want 1/0/0/00000020/1",
                              k, in_flight, wb_fire, wb_valid, pending_mask, hazard_rt);
         end
         tick();
      end
      advance = 1; issue = 0;
      #2;
      n_cmp++;
      if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL stall_resume0: got wbv=%b want 0", wb_valid); end
      tick();
      #2;
      n_cmp++;
      if (wb_valid !== 1'b1 || dest_out !== 5'd5 || wb_fire !== 1'b1) begin
         n_bad++; $display("FAIL stall_resume1: got wbv=%b dest=%0d fire=%b want 1/5/1", wb_valid, dest_out, wb_fire);
      end
      tick();
   endtask

   task automatic test_flush();
      sel = 2'd3; reg_write = 1; advance = 1; issue = 1;
      rd = 5'd3; tick();
      rd = 5'd4; tick();
      flush = 1; sel = 2'd0; rt = 5'd12;
      #2;
      n_cmp++;
      if (in_flight !== 2'd2) begin n_bad++; $display("FAIL flush_pre: got inf=%0d want 2", in_flight); end
      tick();
      flush = 0; issue = 0; rt = 5'd0;
      for (int k = 0; k <= DEPTH; k++) begin
         #2;
         n_cmp++;
         if (wb_valid !== 1'b0 || pending_mask !== '0 || in_flight !== 2'd0) begin
            n_bad++; $display("FAIL flush_post k=%0d: got wbv=%b dest=%0d mask=%h inf=%0d want 0", k, wb_valid, dest_out, pending_mask, in_flight);
         end
         tick();
      end
   endtask

   task automatic test_duplicate();
      int exp_cnt[5] = '{1, 2, 2, 1, 0};
      sel = 2'd3; rd = 5'd9; issue = 1; reg_write = 1; advance = 1; rs_q = 5'd9;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 1) issue = 0;
         #2;
         n_cmp++;
         if (int'(in_flight) !== exp_cnt[k] || pending_mask[9] !== (k < 4) || hazard_rs !== (k < 4)) begin
            n_bad++; $display("FAIL dup k=%0d: got inf=%0d mask9=%b hz=%b want %0d/%b", k, in_flight, pending_mask[9], hazard_rs, exp_cnt[k], k < 4);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] em;
      for (int c = 0; c < 400; c++) begin
         reset     = ($urandom_range(0, 79) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         advance   = ($urandom_range(0, 3) != 0);
         issue     = $urandom_range(0, 1);
         reg_write = ($urandom_range(0, 3) != 0);
         sel       = 2'($urandom_range(0, 3));
         rt        = 5'($urandom_range(0, 7));
         rd        = 5'($urandom_range(0, 7));
         rs_q      = $urandom_range(0, 1) ? 5'(ma[$urandom_range(0, DEPTH-1)]) : 5'($urandom_range(0, 31));
         rt_q      = $urandom_range(0, 1) ? 5'(ma[$urandom_range(0, DEPTH-1)]) : 5'($urandom_range(0, 31));
         #2;
         em = m_mask();
         n_cmp++;
         if (int'(dest_now) !== m_dest(sel, rt, rd)) begin
            n_bad++; $display("FAIL rnd_dest_now c=%0d: got %0d want %0d", c, dest_now, m_dest(sel, rt, rd));
         end
         n_cmp++;
         if (int'(dest_out) !== ma[DEPTH-1] || wb_valid !== mv[DEPTH-1] || wb_fire !== (mv[DEPTH-1] && advance)) begin
            n_bad++; $display("FAIL rnd_wb c=%0d: got dest=%0d wbv=%b fire=%b want %0d/%b/%b", c, dest_out, wb_valid, wb_fire,
                              ma[DEPTH-1], mv[DEPTH-1], mv[DEPTH-1] && advance);
         end
         n_cmp++;
         if (pending_mask !== em || int'(in_flight) !== m_cnt()) begin
            n_bad++; $display("FAIL rnd_score c=%0d: got mask=%h inf=%0d want %h/%0d", c, pending_mask, in_flight, em, m_cnt());
         end
         n_cmp++;
         if (hazard_rs !== (rs_q != 0 && em[rs_q]) || hazard_rt !== (rt_q != 0 && em[rt_q])) begin
            n_bad++; $display("FAIL rnd_hazard c=%0d: got rs=%b rt=%b want %b/%b", c, hazard_rs, hazard_rt,
                              rs_q != 0 && em[rs_q], rt_q != 0 && em[rt_q]);
         end
         tick();
      end
      reset = 0; flush = 0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin mv.push_back(0); ma.push_back(0); end
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_flush();
      test_duplicate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_dest_pipe.md
Name: reg_dest_pipe

Overview:
Parametrised successor to the register-destination select of the multicycle CPU. It resolves the write-destination register from the decode-stage select (RT, $ra, $sp, RD) and carries it through a DEPTH-stage tracking pipeline to writeback. It keeps a scoreboard of pending writes so the control unit can detect RAW hazards on RS/RT. It sits between the decoder/control unit and the register bank write port.

Parameters:
ADDR_W, 5, register address width
NUM_REGS, 32, register count (must equal 2**ADDR_W)
DEPTH, 3, stages from issue to writeback (>=1)
RA_REG, 31, link register index for sel=1
SP_REG, 29, stack pointer index for sel=2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sel  in  2  destination select: 0=rt, 1=RA_REG, 2=SP_REG, 3=rd
rt  in  ADDR_W  inst[20:16]
rd  in  ADDR_W  inst[15:11]
issue  in  1  decode-stage instruction valid this cycle
reg_write  in  1  issued instruction writes the register bank
advance  in  1  pipeline enable; low = stall/hold
flush  in  1  kill all in-flight entries
rs_q  in  ADDR_W  source RS to check for hazard
rt_q  in  ADDR_W  source RT to check for hazard
dest_now  out  ADDR_W  combinational selected destination for the current sel
dest_out  out  ADDR_W  destination address in the writeback stage
wb_valid  out  1  writeback stage holds a live write
wb_fire  out  1  wb_valid & advance; the bank writes this cycle
hazard_rs  out  1  rs_q has a pending write
hazard_rt  out  1  rt_q has a pending write
pending_mask  out  NUM_REGS  one-hot OR of all live stage destinations
in_flight  out  $clog2(DEPTH+1)  count of live stages

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset. Reset is sampled on the rising edge of clk.
- dest_now is a pure mux of sel. Every sel encoding is defined, so no default path is needed.
- Stage state per entry: {v, addr}. Reset clears every v and addr to 0. After reset: dest_out=0, wb_valid=0, wb_fire=0, hazards=0, pending_mask=0, in_flight=0.
- Priority per edge: reset > flush > advance > hold.
- Flush: all v <= 0 and addr held. A concurrent issue is discarded, even if advance=1.
- Advance (no flush): stage0.v <= issue & reg_write & (dest_now != 0); stage0.addr <= dest_now; stage[i] <= stage[i-1] for i = 1..DEPTH-1. The writeback entry retires.
- Hold (advance=0): all stages keep their value. The issuer must hold the instruction; issue is ignored while stalled.
- Writes to $0 never become live. They never raise hazards or a pending_mask bit.
- dest_out and wb_valid come straight from stage DEPTH-1 registers (no combinational path from inputs). wb_fire = wb_valid & advance.
- Latency: a live write issued with advance at edge N shows wb_valid at edge N+DEPTH-1 (visible after that edge), provided advance stays high. With DEPTH=1 it is visible in the cycle after issue.
- pending_mask, hazard_rs, hazard_rt and in_flight are combinational from stage registers only.
- hazard_x = (x_q != 0) & pending_mask[x_q].
- The same register may be live in several stages. The mask bit stays set until the last of them retires.
- in_flight counts live v bits; its range is 0..DEPTH.

Decomposition:
- Shared package cpu_pkg holds: REGDST_RT=2'd0, REGDST_RA=2'd1, REGDST_SP=2'd2, REGDST_RD=2'd3, the RA/SP register index constants, and the stage-entry struct {v, addr}.
- One sub-module is natural: the existing combinational select, generalised to ADDR_W as reg_dest_sel, instantiated to produce dest_now.
- Stage array, scoreboard OR-reduction and popcount use generate loops in the top.

Test Plan:
- Reset then idle, DEPTH=3: all outputs 0 for 5 cycles with advance=1 and issue=0.
- Issue sel=3, rd=8, reg_write=1, advance held 1: wb_valid=1 and dest_out=8 two edges later, wb_fire=1 for one cycle. pending_mask[8]=1 and hazard_rs=1 (rs_q=8) from the cycle after issue until retire.
- Back-to-back: sel=1, then sel=2, then sel=0 with rt=0: dest_out sequence is 31, 29, then no wb_valid. in_flight peaks at 2, and pending_mask never sets bit 0.
- Stall: issue rd=5, drop advance for 4 cycles after one edge. Stage contents are frozen, in_flight=1, wb_fire=0. Resume: wb_valid appears 1 edge later.
- Flush with concurrent issue (rt=12) and two live entries: next cycle in_flight=0, pending_mask=0, and 12 never reaches writeback.
- Duplicate destination: issue rd=9 twice consecutively. pending_mask[9] stays 1 until the second write retires, and in_flight goes 1, 2, then falls to 1 when the first write retires.
